// File: rtl/axi_write_slave_burst.sv
// ---------------------------------------------------------------------------
// axi_write_slave_burst
//
// AXI write slave that accepts one write burst at a time. It computes a device
// address for every beat of a FIXED, INCR or WRAP burst. It forwards each
// accepted beat, with its byte strobes, to a local device write port through a
// valid/ready handshake. A single B response reports OKAY or SLVERR at the end
// of the burst.
//
// Optional feature macro: AXI_WS_WRAP_EN
//   defined   - WRAP bursts are legal and use wrap-boundary address arithmetic.
//   undefined - WRAP bursts are flagged as errors. Their beats are accepted and
//               dropped, and the burst ends with SLVERR.
//
// Parameters
//   DATA_WIDTH  W / device data width (power of two, 8..1024)
//   ADDR_WIDTH  AWADDR / device address width
//   ID_WIDTH    AWID / BID width
//
// Ports
//   ACLK, ARESET                      clock, synchronous active-high reset
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST  write address channel payload
//   AWVALID/AWREADY                   write address handshake
//   WDATA/WSTRB/WLAST                 write data beat
//   WVALID/WREADY                     write data handshake
//   BID/BRESP, BVALID/BREADY          write response (00 OKAY, 10 SLVERR)
//   dev_waddr/dev_wdata/dev_wstrb     device beat payload
//   dev_wvalid/dev_wready             device handshake
// ---------------------------------------------------------------------------
module axi_write_slave_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   dev_waddr,
    output logic [DATA_WIDTH-1:0]   dev_wdata,
    output logic [DATA_WIDTH/8-1:0] dev_wstrb,
    output logic                    dev_wvalid,
    input  logic                    dev_wready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(STRB_WIDTH);
    localparam logic [2:0] MAX_SIZE = 3'(LOG2_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DEV  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [8:0]              r_cnt;
    logic                    r_err;
    logic                    r_last;

    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [ID_WIDTH-1:0]     r_bid;
    logic [1:0]              r_bresp;
    logic                    r_dev_wvalid;
    logic [ADDR_WIDTH-1:0]   r_dev_waddr;
    logic [DATA_WIDTH-1:0]   r_dev_wdata;
    logic [STRB_WIDTH-1:0]   r_dev_wstrb;

    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_dev_fire;
    logic                    w_b_fire;
    logic                    w_aw_err;
    logic                    w_beat_ok;
    logic                    w_wlast_bad;
    logic                    w_err_next;
    logic [ADDR_WIDTH-1:0]   w_size;
    logic [ADDR_WIDTH-1:0]   w_incr;
    logic [ADDR_WIDTH-1:0]   w_addr_next;

    assign AWREADY    = r_awready;
    assign WREADY     = r_wready;
    assign BVALID     = r_bvalid;
    assign BID        = r_bid;
    assign BRESP      = r_bresp;
    assign dev_wvalid = r_dev_wvalid;
    assign dev_waddr  = r_dev_waddr;
    assign dev_wdata  = r_dev_wdata;
    assign dev_wstrb  = r_dev_wstrb;

    // Each ready/valid output is a flop, so it can only be high in its own state.
    assign w_aw_fire  = AWVALID & r_awready;
    assign w_w_fire   = WVALID & r_wready;
    assign w_dev_fire = r_dev_wvalid & dev_wready;
    assign w_b_fire   = r_bvalid & BREADY;

    // Conditions that make the whole burst an error, checked at address accept.
    always_comb begin
        w_aw_err = 1'b0;
        if (AWSIZE > MAX_SIZE) begin
            w_aw_err = 1'b1;
        end
        if (AWBURST == 2'b11) begin
            w_aw_err = 1'b1;
        end
`ifdef AXI_WS_WRAP_EN
        if ((AWBURST == 2'b10) &&
            !((AWLEN == 8'd1) || (AWLEN == 8'd3) || (AWLEN == 8'd7) || (AWLEN == 8'd15))) begin
            w_aw_err = 1'b1;
        end
`else
        if (AWBURST == 2'b10) begin
            w_aw_err = 1'b1;
        end
`endif
    end

    // r_cnt is the zero-based index of the beat being accepted. Beats past
    // AWLEN are dropped. WLAST must coincide with index AWLEN.
    assign w_beat_ok   = !r_err && (r_cnt <= {1'b0, r_len});
    assign w_wlast_bad = WLAST && (r_cnt != {1'b0, r_len});

    // Address advance
    assign w_size = ADDR_WIDTH'(1) << r_size;
    assign w_incr = (r_addr & ~(w_size - ADDR_WIDTH'(1))) + w_size;

`ifdef AXI_WS_WRAP_EN
    logic [ADDR_WIDTH-1:0] w_bound;
    logic [ADDR_WIDTH-1:0] w_wrap;
    // AWLEN+1 is a power of two for any legal wrap, so bound-1 is a clean mask.
    assign w_bound = (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size;
    assign w_wrap  = (r_addr & ~(w_bound - ADDR_WIDTH'(1))) |
                     ((r_addr + w_size) & (w_bound - ADDR_WIDTH'(1)));
`endif

    always_comb begin
        w_addr_next = r_addr;
        case (r_burst)
            2'b01:   w_addr_next = w_incr;
`ifdef AXI_WS_WRAP_EN
            2'b10:   w_addr_next = w_wrap;
`endif
            default: w_addr_next = r_addr;
        endcase
    end

    // Next-state and error flag
    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_aw_fire) begin
                    w_state_next = S_DATA;
                    w_err_next   = w_aw_err;
                end
            end
            S_DATA: begin
                if (w_w_fire) begin
                    if (w_wlast_bad) begin
                        w_err_next = 1'b1;
                    end
                    // Forwarding depends on the flag from before this beat.
                    // An early WLAST beat is still written to the device.
                    if (w_beat_ok) begin
                        w_state_next = S_DEV;
                    end else if (WLAST) begin
                        w_state_next = S_RESP;
                    end
                end
            end
            S_DEV: begin
                if (w_dev_fire) begin
                    w_state_next = r_last ? S_RESP : S_DATA;
                end
            end
            S_RESP: begin
                if (w_b_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= S_IDLE;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_last       <= 1'b0;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bid        <= '0;
            r_bresp      <= 2'b00;
            r_dev_wvalid <= 1'b0;
            r_dev_waddr  <= '0;
            r_dev_wdata  <= '0;
            r_dev_wstrb  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_err        <= w_err_next;
            // Handshake outputs are registered versions of the next state.
            r_awready    <= (w_state_next == S_IDLE);
            r_wready     <= (w_state_next == S_DATA);
            r_dev_wvalid <= (w_state_next == S_DEV);
            r_bvalid     <= (w_state_next == S_RESP);

            if (w_aw_fire) begin
                r_id    <= AWID;
                r_addr  <= AWADDR;
                r_len   <= AWLEN;
                r_size  <= AWSIZE;
                r_burst <= AWBURST;
                r_cnt   <= '0;
            end

            if (w_w_fire) begin
                r_dev_waddr <= r_addr;
                r_dev_wdata <= WDATA;
                r_dev_wstrb <= WSTRB;
                r_last      <= WLAST;
                // Saturate so a runaway burst without WLAST cannot wrap back
                // into the forwarded range.
                if (r_cnt != 9'h1FF) begin
                    r_cnt <= r_cnt + 9'd1;
                end
            end

            if (w_dev_fire) begin
                r_addr <= w_addr_next;
            end

            // Response fields are captured once, on entry to RESP, and then
            // held until BREADY.
            if ((r_state != S_RESP) && (w_state_next == S_RESP)) begin
                r_bid   <= r_id;
                r_bresp <= w_err_next ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_axi_write_slave_burst.sv
// ---------------------------------------------------------------------------
// tb_axi_write_slave_burst
//
// Directed testbench for axi_write_slave_burst with a 32-bit data bus,
// 32-bit addresses and 4-bit IDs. Inputs change #1 after the rising edge.
// Outputs are sampled on the falling edge. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_axi_write_slave_burst;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] dev_waddr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_wstrb;
    logic        dev_wvalid;
    logic        dev_wready;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi_write_slave_burst #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .ID_WIDTH   (4)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .AWID       (AWID),
        .AWADDR     (AWADDR),
        .AWLEN      (AWLEN),
        .AWSIZE     (AWSIZE),
        .AWBURST    (AWBURST),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .WLAST      (WLAST),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .BID        (BID),
        .BRESP      (BRESP),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .dev_waddr  (dev_waddr),
        .dev_wdata  (dev_wdata),
        .dev_wstrb  (dev_wstrb),
        .dev_wvalid (dev_wvalid),
        .dev_wready (dev_wready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"},    64'(AWREADY),    64'h0);
        check({tag, "_wready"},     64'(WREADY),     64'h0);
        check({tag, "_bvalid"},     64'(BVALID),     64'h0);
        check({tag, "_bresp"},      64'(BRESP),      64'h0);
        check({tag, "_bid"},        64'(BID),        64'h0);
        check({tag, "_dev_wvalid"}, 64'(dev_wvalid), 64'h0);
        check({tag, "_dev_waddr"},  64'(dev_waddr),  64'h0);
        check({tag, "_dev_wdata"},  64'(dev_wdata),  64'h0);
        check({tag, "_dev_wstrb"},  64'(dev_wstrb),  64'h0);
    endtask

    // Present an AW request and wait for it to be accepted. Then check that
    // the slave has moved to the data phase.
    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input string tag);
        int n;
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = len;
        AWSIZE  = size;
        AWBURST = burst;
        AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_aw_wait"}, 64'(AWREADY), 64'h1);
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        @(negedge ACLK);
        check({tag, "_aw_wready"},  64'(WREADY),  64'h1);
        check({tag, "_aw_awready"}, 64'(AWREADY), 64'h0);
        $display("AW   %s id=%0h addr=%08h len=%0d size=%0d burst=%0d", tag, id, addr, len, size, burst);
    endtask

    // Send one W beat and service the device side. The device stalls for
    // 'stall' cycles before it asserts dev_wready.
    task automatic beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic exp_dev, input logic [31:0] exp_addr, input int stall,
                        input string tag);
        int n;
        WDATA  = data;
        WSTRB  = strb;
        WLAST  = last;
        WVALID = 1'b1;
        n = 0;
        while (!WREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_w_wait"}, 64'(WREADY), 64'h1);
        @(posedge ACLK);
        #1 WVALID = 1'b0;
        WLAST = 1'b0;
        @(negedge ACLK);
        if (exp_dev) begin
            check({tag, "_dev_wvalid"}, 64'(dev_wvalid), 64'h1);
            check({tag, "_dev_waddr"},  64'(dev_waddr),  64'(exp_addr));
            check({tag, "_dev_wdata"},  64'(dev_wdata),  64'(data));
            check({tag, "_dev_wstrb"},  64'(dev_wstrb),  64'(strb));
            check({tag, "_wready_low"}, 64'(WREADY),     64'h0);
            for (int k = 0; k < stall; k++) begin
                @(negedge ACLK);
                check({tag, "_stall_wvalid"}, 64'(dev_wvalid), 64'h1);
                check({tag, "_stall_waddr"},  64'(dev_waddr),  64'(exp_addr));
                check({tag, "_stall_wdata"},  64'(dev_wdata),  64'(data));
                check({tag, "_stall_wstrb"},  64'(dev_wstrb),  64'(strb));
                check({tag, "_stall_wready"}, 64'(WREADY),     64'h0);
            end
            dev_wready = 1'b1;
            @(posedge ACLK);
            #1 dev_wready = 1'b0;
            @(negedge ACLK);
            check({tag, "_dev_done"}, 64'(dev_wvalid), 64'h0);
            $display("BEAT %s dev addr=%08h data=%08h strb=%h last=%0d", tag, exp_addr, data, strb, last);
        end else begin
            check({tag, "_dropped"}, 64'(dev_wvalid), 64'h0);
            $display("BEAT %s dropped data=%08h last=%0d", tag, data, last);
        end
        if (last) begin
            check({tag, "_next_bvalid"}, 64'(BVALID), 64'h1);
        end else begin
            check({tag, "_next_wready"}, 64'(WREADY), 64'h1);
        end
    endtask

    // Check the response, hold BREADY low for 'hold' cycles, then complete it.
    task automatic resp(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int hold,
                        input string tag);
        check({tag, "_bvalid"}, 64'(BVALID), 64'h1);
        check({tag, "_bid"},    64'(BID),    64'(exp_id));
        check({tag, "_bresp"},  64'(BRESP),  64'(exp_resp));
        for (int k = 0; k < hold; k++) begin
            @(negedge ACLK);
            check({tag, "_hold_bvalid"},  64'(BVALID),  64'h1);
            check({tag, "_hold_bid"},     64'(BID),     64'(exp_id));
            check({tag, "_hold_bresp"},   64'(BRESP),   64'(exp_resp));
            check({tag, "_hold_awready"}, 64'(AWREADY), 64'h0);
        end
        BREADY = 1'b1;
        @(posedge ACLK);
        #1 BREADY = 1'b0;
        @(negedge ACLK);
        check({tag, "_b_done"},  64'(BVALID),  64'h0);
        check({tag, "_awready"}, 64'(AWREADY), 64'h1);
        $display("RESP %s bid=%0h bresp=%0d", tag, BID, BRESP);
    endtask

    initial begin
        logic [31:0] wrap_addr [4];
        ARESET     = 1'b1;
        AWID       = '0;
        AWADDR     = '0;
        AWLEN      = '0;
        AWSIZE     = '0;
        AWBURST    = '0;
        AWVALID    = 1'b0;
        WDATA      = '0;
        WSTRB      = '0;
        WLAST      = 1'b0;
        WVALID     = 1'b0;
        BREADY     = 1'b0;
        dev_wready = 1'b0;

        // Reset state, then AWREADY on the first cycle after release
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs("por");
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("por_awready_rise", 64'(AWREADY), 64'h1);

        // INCR 4 beats from 0x100
        send_aw(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, "incr");
        for (int i = 0; i < 4; i++) begin
            beat(32'hA000_0000 + 32'(i), 4'hF, (i == 3), 1'b1, 32'h100 + 32'(4 * i), 0,
                 $sformatf("incr_b%0d", i));
        end
        resp(4'h5, 2'b00, 0, "incr");

        // Unaligned INCR: the second beat aligns to the size boundary
        send_aw(4'h6, 32'h102, 8'd1, 3'd2, 2'b01, "unal");
        beat(32'h1234_5678, 4'hC, 1'b0, 1'b1, 32'h102, 0, "unal_b0");
        beat(32'h9ABC_DEF0, 4'hF, 1'b1, 1'b1, 32'h104, 0, "unal_b1");
        resp(4'h6, 2'b00, 0, "unal");

        // WRAP 4 beats from 0x38
        wrap_addr[0] = 32'h38;
        wrap_addr[1] = 32'h3C;
        wrap_addr[2] = 32'h30;
        wrap_addr[3] = 32'h34;
        send_aw(4'h3, 32'h38, 8'd3, 3'd2, 2'b10, "wrap");
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_WS_WRAP_EN
            beat(32'hB000_0000 + 32'(i), 4'hF, (i == 3), 1'b1, wrap_addr[i], 0,
                 $sformatf("wrap_b%0d", i));
`else
            beat(32'hB000_0000 + 32'(i), 4'hF, (i == 3), 1'b0, wrap_addr[i], 0,
                 $sformatf("wrap_b%0d", i));
`endif
        end
`ifdef AXI_WS_WRAP_EN
        resp(4'h3, 2'b00, 0, "wrap");
`else
        resp(4'h3, 2'b10, 0, "wrap");
`endif

        // FIXED with a 3-cycle device stall on every beat
        send_aw(4'h9, 32'h20, 8'd2, 3'd2, 2'b00, "fixed");
        for (int i = 0; i < 3; i++) begin
            beat(32'hC000_0000 + 32'(i), 4'h3, (i == 2), 1'b1, 32'h20, 3,
                 $sformatf("fixed_b%0d", i));
        end
        resp(4'h9, 2'b00, 0, "fixed");

        // Oversized beat: both beats are dropped
        send_aw(4'h2, 32'h40, 8'd1, 3'd3, 2'b01, "size");
        beat(32'hD000_0000, 4'hF, 1'b0, 1'b0, 32'h40, 0, "size_b0");
        beat(32'hD000_0001, 4'hF, 1'b1, 1'b0, 32'h40, 0, "size_b1");
        resp(4'h2, 2'b10, 0, "size");

        // Reserved burst type
        send_aw(4'hE, 32'h50, 8'd0, 3'd2, 2'b11, "rsvd");
        beat(32'hE000_0000, 4'hF, 1'b1, 1'b0, 32'h50, 0, "rsvd_b0");
        resp(4'hE, 2'b10, 0, "rsvd");

        // Early WLAST on beat 2 of 4: both beats are written, then SLVERR
        send_aw(4'h7, 32'h200, 8'd3, 3'd2, 2'b01, "early");
        beat(32'hF000_0000, 4'hF, 1'b0, 1'b1, 32'h200, 0, "early_b0");
        beat(32'hF000_0001, 4'hF, 1'b1, 1'b1, 32'h204, 0, "early_b1");
        resp(4'h7, 2'b10, 0, "early");

        // The error does not carry into the next burst. BREADY is held low.
        send_aw(4'h1, 32'h300, 8'd0, 3'd2, 2'b01, "single");
        beat(32'h0BAD_CAFE, 4'h5, 1'b1, 1'b1, 32'h300, 0, "single_b0");
        resp(4'h1, 2'b00, 5, "single");

        // Reset mid-burst while beat 1 is waiting at the device
        send_aw(4'hA, 32'h400, 8'd3, 3'd2, 2'b01, "rst");
        beat(32'h5555_0000, 4'hF, 1'b0, 1'b1, 32'h400, 0, "rst_b0");
        WDATA  = 32'h5555_0001;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        @(posedge ACLK);
        #1 WVALID = 1'b0;
        @(negedge ACLK);
        check("rst_pending_wvalid", 64'(dev_wvalid), 64'h1);
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs("midrst");
        $display("RST  mid-burst reset applied");
        #1 ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("midrst_awready", 64'(AWREADY), 64'h1);
        check("midrst_no_bvalid", 64'(BVALID), 64'h0);

        // The slave is fully usable after the reset
        send_aw(4'h4, 32'h500, 8'd0, 3'd2, 2'b01, "post");
        beat(32'h7777_7777, 4'hF, 1'b1, 1'b1, 32'h500, 0, "post_b0");
        resp(4'h4, 2'b00, 0, "post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
